// File: rtl/busqueda_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Latency: none (package only).
// Backpressure: none (package only).
// Holds the FSM state type, PC defaults, instruction field positions and the
// R-type opcode value that the decode control unit also uses.
package busqueda_pkg;

   typedef enum logic {
      REQ        = 1'b0,
      WAIT_SPACE = 1'b1
   } state_t;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int unsigned PC_INC_DEF   = 4;

   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

endpackage

// File: rtl/buffer_salto_fetch.sv
// 2-entry output buffer (output register + skid entry) between fetch and decode.
// Latency: a push is visible on out_* the cycle after it is accepted.
// Backpressure: a push while the output is held and not fired lands in skid; full = skid occupied.
// Ports: push/push_instr/push_pc4 (new response), fire (output consumed),
//        flush (drop both entries), valid/out_instr/out_pc4 (output entry), full.
module buffer_salto_fetch #(
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic [31:0]       push_instr,
   input  logic [ADDR_W-1:0] push_pc4,
   input  logic              fire,
   input  logic              flush,
   output logic              valid,
   output logic              full,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc4
);

   logic              out_vld_q, out_vld_d;
   logic [31:0]       out_instr_q, out_instr_d;
   logic [ADDR_W-1:0] out_pc4_q, out_pc4_d;
   logic              skid_vld_q, skid_vld_d;
   logic [31:0]       skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0] skid_pc4_q, skid_pc4_d;

   always_comb begin
      out_vld_d    = out_vld_q;
      out_instr_d  = out_instr_q;
      out_pc4_d    = out_pc4_q;
      skid_vld_d   = skid_vld_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      if (flush) begin
         // Data is left in place; only the valid bits matter downstream.
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end else if (!out_vld_q || fire) begin
         // Output slot frees up this edge: skid has priority to keep order.
         if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_instr_d = skid_instr_q;
            out_pc4_d   = skid_pc4_q;
            skid_vld_d  = push;
            if (push) begin
               skid_instr_d = push_instr;
               skid_pc4_d   = push_pc4;
            end
         end else begin
            out_vld_d = push;
            if (push) begin
               out_instr_d = push_instr;
               out_pc4_d   = push_pc4;
            end
         end
      end else if (push) begin
         skid_vld_d   = 1'b1;
         skid_instr_d = push_instr;
         skid_pc4_d   = push_pc4;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_vld_q    <= 1'b0;
         out_instr_q  <= '0;
         out_pc4_q    <= '0;
         skid_vld_q   <= 1'b0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
      end else begin
         out_vld_q    <= out_vld_d;
         out_instr_q  <= out_instr_d;
         out_pc4_q    <= out_pc4_d;
         skid_vld_q   <= skid_vld_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

   assign valid     = out_vld_q;
   assign full      = skid_vld_q;
   assign out_instr = out_instr_q;
   assign out_pc4   = out_pc4_q;

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: PC, req/ready imem port, redirect handling, decode handoff.
// Latency: id_valid rises the cycle after imem_ready; one instruction/cycle at zero wait.
// Backpressure: stall holds id_*; a second response goes to skid and fetch pauses until it drains.
// Ports: clk/rst_n; imem_req/imem_addr/imem_ready/imem_rdata (memory);
//        stall/redirect/redirect_pc (later stages); id_valid/id_instr/id_pc4/id_opcode/id_funct (decode).
module etapa_busqueda
   import busqueda_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
   parameter int unsigned       PC_INC   = PC_INC_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              id_valid,
   output logic [31:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc4,
   output logic [5:0]        id_opcode,
   output logic [5:0]        id_funct
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
   logic              drop_q, drop_d;
   logic [ADDR_W-1:0] pc_next;
   logic              fire;
   logic              push;
   logic              buf_full;

   assign pc_next = pc_q + ADDR_W'(PC_INC);
   assign fire    = id_valid & ~stall;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pend_pc_d = pend_pc_q;
      drop_d    = drop_q;
      push      = 1'b0;
      imem_req  = rst_n & (state_q == REQ);
      imem_addr = pc_q;
      if (redirect) begin
         if (state_q == REQ && !imem_ready) begin
            // Request in flight: address must stay put, so park the target
            // and discard whatever comes back for the old address.
            drop_d    = 1'b1;
            pend_pc_d = redirect_pc;
         end else begin
            pc_d    = redirect_pc;
            state_d = REQ;
            drop_d  = 1'b0;
         end
      end else if (state_q == REQ) begin
         if (imem_ready) begin
            if (drop_q) begin
               pc_d   = pend_pc_q;
               drop_d = 1'b0;
            end else begin
               pc_d = pc_next;
               push = 1'b1;
               // Lands in skid when the output is held; pause fetching.
               if (id_valid && !fire) begin
                  state_d = WAIT_SPACE;
               end
            end
         end
      end else begin
         if (fire || !buf_full) begin
            state_d = REQ;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= REQ;
         pc_q      <= RESET_PC;
         pend_pc_q <= RESET_PC;
         drop_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         pend_pc_q <= pend_pc_d;
         drop_q    <= drop_d;
      end
   end

   buffer_salto_fetch #(
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_instr (imem_rdata),
      .push_pc4   (pc_next),
      .fire       (fire),
      .flush      (redirect),
      .valid      (id_valid),
      .full       (buf_full),
      .out_instr  (id_instr),
      .out_pc4    (id_pc4)
   );

   assign id_opcode = id_instr[OPCODE_MSB:OPCODE_LSB];
   assign id_funct  = id_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: tb/tb_etapa_busqueda.sv
module tb_etapa_busqueda;
   import busqueda_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_pc4;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;

   logic        zero_wait;
   logic        man_ready;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_0040) return 32'h0000_0020;
      return 32'hC000_0000 ^ a;
   endfunction

   assign imem_ready = zero_wait ? imem_req : man_ready;
   assign imem_rdata = mem_word(imem_addr);

   etapa_busqueda dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_valid    (id_valid),
      .id_instr    (id_instr),
      .id_pc4      (id_pc4),
      .id_opcode   (id_opcode),
      .id_funct    (id_funct)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n       = 1'b0;
      zero_wait   = 1'b1;
      man_ready   = 1'b0;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      tick();
      tick();
      chk("rst_req",   {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, id_valid}, 32'd0);
      chk("rst_instr", id_instr, 32'd0);
      chk("rst_pc4",   id_pc4, 32'd0);

      // 1: zero-wait sequential stream
      rst_n = 1'b1;
      #1;
      chk("t1_req0",   {31'b0, imem_req}, 32'd1);
      chk("t1_addr0",  imem_addr, 32'h0);
      chk("t1_valid0", {31'b0, id_valid}, 32'd0);
      tick();
      chk("t1_addr4",  imem_addr, 32'h4);
      chk("t1_valid1", {31'b0, id_valid}, 32'd1);
      chk("t1_pc4_a",  id_pc4, 32'h4);
      chk("t1_instr0", id_instr, mem_word(32'h0));
      tick();
      chk("t1_addr8",  imem_addr, 32'h8);
      chk("t1_pc4_b",  id_pc4, 32'h8);
      chk("t1_instr4", id_instr, mem_word(32'h4));
      tick();
      chk("t1_addr12", imem_addr, 32'hC);
      chk("t1_pc4_c",  id_pc4, 32'hC);

      // 2: zero-wait redirect to 0x40, which holds an R-type word
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect = 1'b0;
      chk("t2_valid0", {31'b0, id_valid}, 32'd0);
      chk("t2_addr",   imem_addr, 32'h40);
      tick();
      chk("t2_valid1", {31'b0, id_valid}, 32'd1);
      chk("t2_instr",  id_instr, 32'h0000_0020);
      chk("t2_opcode", {26'b0, id_opcode}, {26'b0, OP_RTYPE});
      chk("t2_funct",  {26'b0, id_funct}, 32'h20);
      chk("t2_pc4",    id_pc4, 32'h44);

      // 3: stall for 3 cycles; 0x44 response goes to skid
      stall = 1'b1;
      tick();
      chk("t3_req_a",   {31'b0, imem_req}, 32'd0);
      chk("t3_instr_a", id_instr, 32'h0000_0020);
      chk("t3_pc4_a",   id_pc4, 32'h44);
      tick();
      chk("t3_req_b",   {31'b0, imem_req}, 32'd0);
      chk("t3_valid_b", {31'b0, id_valid}, 32'd1);
      tick();
      chk("t3_pc4_c",   id_pc4, 32'h44);
      stall = 1'b0;
      tick();
      chk("t3_instr44", id_instr, mem_word(32'h44));
      chk("t3_pc4_48",  id_pc4, 32'h48);
      chk("t3_req_d",   {31'b0, imem_req}, 32'd1);
      chk("t3_addr48",  imem_addr, 32'h48);
      tick();
      chk("t3_instr48", id_instr, mem_word(32'h48));
      chk("t3_pc4_4c",  id_pc4, 32'h4C);

      // 4: redirect to 0x100 while 0x4C request waits 2 cycles
      zero_wait   = 1'b0;
      man_ready   = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      chk("t4_valid_a", {31'b0, id_valid}, 32'd0);
      chk("t4_addr_a",  imem_addr, 32'h4C);
      chk("t4_req_a",   {31'b0, imem_req}, 32'd1);
      tick();
      chk("t4_addr_b",  imem_addr, 32'h4C);
      man_ready = 1'b1;
      tick();
      man_ready = 1'b0;
      chk("t4_valid_c", {31'b0, id_valid}, 32'd0);
      chk("t4_addr100", imem_addr, 32'h100);
      chk("t4_req_c",   {31'b0, imem_req}, 32'd1);
      zero_wait = 1'b1;
      tick();
      chk("t4_valid_d", {31'b0, id_valid}, 32'd1);
      chk("t4_instr",   id_instr, mem_word(32'h100));
      chk("t4_pc4",     id_pc4, 32'h104);

      // 5: redirect + stall with both entries full
      stall = 1'b1;
      tick();
      chk("t5_req_full", {31'b0, imem_req}, 32'd0);
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      tick();
      redirect = 1'b0;
      chk("t5_valid", {31'b0, id_valid}, 32'd0);
      chk("t5_addr",  imem_addr, 32'h200);
      chk("t5_req",   {31'b0, imem_req}, 32'd1);
      stall = 1'b0;

      // 6: PC wrap from 0xFFFF_FFFC
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      chk("t6_addr_top", imem_addr, 32'hFFFF_FFFC);
      chk("t6_valid0",   {31'b0, id_valid}, 32'd0);
      tick();
      chk("t6_addr_wrap", imem_addr, 32'h0);
      chk("t6_valid1",    {31'b0, id_valid}, 32'd1);
      chk("t6_pc4",       id_pc4, 32'h0);
      chk("t6_instr",     id_instr, mem_word(32'hFFFF_FFFC));

      // 7: one-cycle reset mid-stream
      tick();
      chk("t7_pc4_pre", id_pc4, 32'h4);
      rst_n = 1'b0;
      tick();
      chk("t7_valid", {31'b0, id_valid}, 32'd0);
      chk("t7_req",   {31'b0, imem_req}, 32'd0);
      chk("t7_instr", id_instr, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("t7_addr_rst", imem_addr, 32'h0);
      chk("t7_req_rel",  {31'b0, imem_req}, 32'd1);
      tick();
      chk("t7_valid_rel", {31'b0, id_valid}, 32'd1);
      chk("t7_pc4_rel",   id_pc4, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/etapa_busqueda.md
Name: etapa_busqueda

Overview:
- Instruction-fetch stage: holds the PC, fetches 32-bit instructions over a req/ready instruction-memory port, and presents them to the decode stage.
- The decode stage's control unit takes its 6-bit OpCode from id_opcode.
- Contains a 2-entry output buffer (output register plus skid entry) so decode stalls never drop an instruction.
- Handles branch redirects (PC reload plus flush) from later stages.

Parameters:
- ADDR_W, 32, width of PC and memory address.
- RESET_PC, 32'h0000_0000, PC value after reset.
- PC_INC, 4, byte increment per sequential fetch.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request; held high until imem_ready is sampled.
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1.
- imem_ready  in  1  response valid this cycle; may assert in the same cycle as imem_req.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- stall  in  1  decode cannot accept; id_* must hold.
- redirect  in  1  taken branch/jump; flush and reload PC.
- redirect_pc  in  ADDR_W  new fetch address.
- id_valid  out  1  id_instr valid.
- id_instr  out  32  instruction to decode.
- id_pc4  out  ADDR_W  fetch address + PC_INC of id_instr.
- id_opcode  out  6  id_instr[31:26], combinational slice.
- id_funct  out  6  id_instr[5:0], combinational slice.

Behaviour:
- Reset (rst_n=0 at an edge): pc=RESET_PC, state=REQ, id_valid=0, id_instr=0, id_pc4=0, skid empty, drop=0. imem_req is 0 while rst_n=0 and first rises in the cycle after reset release.
- fire = id_valid & ~stall. The output entry is consumed at that edge.
- FSM has two states:
  - REQ: imem_req=1, imem_addr=pc.
  - WAIT_SPACE: imem_req=0.
- Invariant: skid is empty whenever state=REQ, so every response has room.
- REQ & imem_ready & ~drop:
  - pc<=pc+PC_INC. Wrap is modulo 2^ADDR_W, e.g. 0xFFFF_FFFC -> 0.
  - The response {rdata, pc+PC_INC} goes to the output entry if it is empty or fire=1; otherwise it goes to skid.
  - Next state is WAIT_SPACE if skid becomes occupied, else REQ.
- WAIT_SPACE: on fire, skid moves to the output entry, skid clears, and the state returns to REQ. Without fire, the FSM holds.
- Latency: with no stalls and zero-wait memory, one instruction per cycle; id_valid rises the cycle after the first imem_ready.
- Stall: id_valid, id_instr and id_pc4 hold unchanged while stall=1.
- Redirect (highest priority, overrides stall):
  - Output entry and skid are invalidated, so id_valid=0 at the next edge.
  - If state=REQ & imem_ready=0, a request is outstanding: set drop=1 and pend_pc<=redirect_pc. imem_addr stays at the old pc until ready. The response then arriving is discarded, pc<=pend_pc, drop<=0, and the FSM stays in REQ.
  - Otherwise pc<=redirect_pc, state<=REQ, and any same-cycle response is discarded.
  - A redirect arriving while drop=1 overwrites pend_pc.
- Responses with drop=1 never reach id_*.
- Mid-operation reset clears everything as above; an outstanding request is abandoned, since the memory shares the same reset.

Decomposition:
- Package busqueda_pkg holds:
  - state enum {REQ, WAIT_SPACE};
  - RESET_PC and PC_INC defaults;
  - field constants OPCODE_MSB=31, OPCODE_LSB=26, FUNCT_MSB=5, FUNCT_LSB=0;
  - the 6'b000000 R-type opcode constant shared with the control unit.
- One sub-module: buffer_salto_fetch, the 2-entry output/skid buffer with push, fire, flush, full and valid. The FSM, PC and drop logic stay in the top.

Test Plan:
1. Zero-wait memory (imem_ready=req), no stall, from reset -> imem_addr 0, 4, 8, 12 on consecutive cycles; id_pc4 = 4, 8, 12; id_valid=1 from the 2nd cycle after release.
2. Instruction 32'h0000_0020 fetched -> id_opcode=6'b000000, id_funct=6'b100000.
3. Stall held 3 cycles in steady stream -> id_instr frozen; skid fills; imem_req=0 in WAIT_SPACE; after release, the instructions at 4 and 8 appear in order with none lost or duplicated.
4. Redirect to 0x100 while memory returns ready 2 cycles late -> imem_addr holds the old address until ready; that response is discarded; next imem_addr=0x100; id_valid=0 until the 0x100 instruction arrives.
5. Redirect and stall asserted together with both entries full -> id_valid=0 next cycle and pc=redirect_pc.
6. redirect_pc=0xFFFF_FFFC, zero-wait -> next imem_addr=0x0000_0000.
7. rst_n=0 for one cycle mid-stream -> next cycle id_valid=0, imem_req=0; after release the first request goes to RESET_PC.
